paddle_contact_scan: RTL and testbench
======================================

Name: paddle_contact_scan

Overview:
Parametrised, sequential successor to the four-paddle contact finder in the pong datapath.
- Accepts a ball position plus the four paddle positions under a valid strobe.
- Scans the four sides one per cycle and reports which paddles the ball touches, plus the strike offset along the winning paddle.
- Sits between the ball-position register and the ball-direction/score logic.

Parameters:
GRID_W, 8, playfield cells per axis (square grid, power of two)
POS_BITS, 3, bits per ball coordinate; equals log2(GRID_W)
PAD_BITS, 4, width of each paddle position input
PAD_LEN, 2, paddle length in cells; paddle at p covers p..p+PAD_LEN-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
pos_valid  in  1  request strobe; pos/paddles sampled when accepted
pos  in  2*POS_BITS  ball position {x, y}; x = upper POS_BITS, y = lower POS_BITS
player_pos_top  in  PAD_BITS  top paddle start column
player_pos_down  in  PAD_BITS  bottom paddle start column
player_pos_left  in  PAD_BITS  left paddle start row
player_pos_right  in  PAD_BITS  right paddle start row
busy  out  1  high whenever the FSM is not IDLE
result_valid  out  1  one-cycle pulse; result outputs updated this cycle
hit_sides  out  4  bit0 top, bit1 down, bit2 left, bit3 right
contact  out  2  {x_contact, y_contact}; x = top|down hit, y = left|right hit
hit_offset  out  PAD_BITS  coord minus paddle start, for the lowest-index hit side; 0 if no hit
miss_sides  out  4  same bit order as hit_sides; see Optional Feature

Behaviour:
- Reset: FSM to IDLE. busy=0, result_valid=0, hit_sides=0, contact=0, hit_offset=0, miss_sides=0. All internal latches cleared.
- States and transitions:
  - IDLE -> SCAN on pos_valid=1. pos and all four paddle inputs are latched on that edge; side index = 0.
  - SCAN: evaluates side index 0..3, one side per cycle, in order top, down, left, right. Moves to DONE after index 3.
  - DONE: result outputs load from the scan accumulators; result_valid=1 for this cycle; next state IDLE.
- Latency and throughput:
  - If pos_valid is sampled at edge k, result_valid is high during the cycle following edge k+5.
  - Minimum request spacing is 6 cycles.
- pos_valid while busy=1 is ignored: no queuing, latched values unchanged.
- Side test, using latched values:
  - Top: y == 1; coordinate c = x; paddle = top.
  - Down: y == GRID_W-2; c = x; paddle = down.
  - Left: x == 1; c = y; paddle = left.
  - Right: x == GRID_W-2; c = y; paddle = right.
- Hit condition: c >= p and c <= p+PAD_LEN-1.
  - Compare with PAD_BITS+1-bit unsigned arithmetic; p+PAD_LEN must not wrap.
  - A paddle partly off-grid still hits on its on-grid cells.
- Multiple hits, e.g. corner cell (1,1): all matching bits are set in hit_sides. hit_offset comes from the lowest-index hit side.
- Result outputs (hit_sides, contact, hit_offset, miss_sides) hold until the next DONE or reset.
- rst during SCAN or DONE: immediate return to IDLE, outputs cleared, no result_valid pulse for the aborted request.
- rst and pos_valid in the same cycle: reset wins, request dropped.

Optional Feature:
EDGE_MISS_EN
- Defined: during scan, also flag a miss for a side when the ball is on that side's outer boundary cell:
  - top: y == 0
  - down: y == GRID_W-1
  - left: x == 0
  - right: x == GRID_W-1
  The flag is set in miss_sides, with the same timing as hit_sides.
- Undefined: miss_sides is held at 0 and no miss logic is synthesised. Port list is identical in both builds.

Test Plan:
1. Assert rst for 2 cycles -> busy=0, result_valid=0, hit_sides=0000, contact=00, hit_offset=0, miss_sides=0000.
2. pos={x=1,y=3}, left=3, others=0, pulse pos_valid -> result_valid exactly at cycle k+6; hit_sides=0100, contact=01, hit_offset=0.
3. pos={x=1,y=5}, left=3 (covers rows 3,4) -> hit_sides=0000, contact=00, hit_offset=0; then left=4 -> hit_sides=0100, hit_offset=1.
4. Corner pos={x=1,y=1}, top=1, left=0 -> hit_sides=0101, contact=11, hit_offset=0 (taken from top); pos={x=6,y=6}, down=5, right=6 -> hit_sides=1010, hit_offset=1.
5. pos_valid re-pulsed on cycles k+2 and k+4 -> single result_valid, result from the first request only. Separately, rst on SCAN cycle 2 -> no result_valid, outputs 0, next request completes normally.
6. pos={x=0,y=4} -> with EDGE_MISS_EN, miss_sides=0100 and hit_sides=0000; without the macro, miss_sides=0000.

Source files
------------

// File: rtl/paddle_contact_scan.sv
// Sequential four-side paddle contact scanner: latches a ball position and paddles, tests one side
// per cycle, then publishes hit/miss flags and the strike offset. Optional macro: EDGE_MISS_EN.
module paddle_contact_scan #(
  parameter int unsigned GRID_W   = 8,
  parameter int unsigned POS_BITS = 3,
  parameter int unsigned PAD_BITS = 4,
  parameter int unsigned PAD_LEN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pos_valid,
  input  logic [2*POS_BITS-1:0] pos,
  input  logic [PAD_BITS-1:0]   player_pos_top,
  input  logic [PAD_BITS-1:0]   player_pos_down,
  input  logic [PAD_BITS-1:0]   player_pos_left,
  input  logic [PAD_BITS-1:0]   player_pos_right,
  output logic                  busy,
  output logic                  result_valid,
  output logic [3:0]            hit_sides,
  output logic [1:0]            contact,
  output logic [PAD_BITS-1:0]   hit_offset,
  output logic [3:0]            miss_sides
);

  localparam logic [POS_BITS-1:0] NearLo = POS_BITS'(1);
  localparam logic [POS_BITS-1:0] NearHi = POS_BITS'(GRID_W - 2);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                         state_q, state_d;
  logic [1:0]                     idx_q;
  logic [POS_BITS-1:0]            x_q, y_q;
  logic [3:0][PAD_BITS-1:0]       pad_q;
  logic [3:0]                     hit_acc_q, miss_acc_q;
  logic [PAD_BITS-1:0]            off_acc_q;
  logic                           rv_q;
  logic [3:0]                     hit_q, miss_q;
  logic [1:0]                     contact_q;
  logic [PAD_BITS-1:0]            off_q;

  logic                           accept;
  logic                           on_line;
  logic [POS_BITS-1:0]            coord;
  logic [PAD_BITS:0]              c_ext, p_ext, p_end;
  logic                           hit_now, miss_now;
  logic [PAD_BITS-1:0]            off_now;

  assign accept = (state_q == StIdle) && pos_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pos_valid) state_d = StScan;
      StScan:  if (idx_q == 2'd3) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Side order: 0 top, 1 down, 2 left, 3 right.
  always_comb begin
    on_line = 1'b0;
    coord   = '0;
    unique case (idx_q)
      2'd0: begin on_line = (y_q == NearLo); coord = x_q; end
      2'd1: begin on_line = (y_q == NearHi); coord = x_q; end
      2'd2: begin on_line = (x_q == NearLo); coord = y_q; end
      2'd3: begin on_line = (x_q == NearHi); coord = y_q; end
      default: ;
    endcase
  end

  // One extra bit so the paddle end never wraps.
  assign c_ext   = (PAD_BITS+1)'(coord);
  assign p_ext   = (PAD_BITS+1)'(pad_q[idx_q]);
  assign p_end   = p_ext + (PAD_BITS+1)'(PAD_LEN - 1);
  assign hit_now = on_line && (c_ext >= p_ext) && (c_ext <= p_end);
  assign off_now = PAD_BITS'(c_ext - p_ext);

`ifdef EDGE_MISS_EN
  localparam logic [POS_BITS-1:0] EdgeHi = POS_BITS'(GRID_W - 1);

  always_comb begin
    miss_now = 1'b0;
    unique case (idx_q)
      2'd0: miss_now = (y_q == '0);
      2'd1: miss_now = (y_q == EdgeHi);
      2'd2: miss_now = (x_q == '0);
      2'd3: miss_now = (x_q == EdgeHi);
      default: ;
    endcase
  end
`else
  assign miss_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pad_q      <= '0;
      hit_acc_q  <= '0;
      miss_acc_q <= '0;
      off_acc_q  <= '0;
      rv_q       <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
      contact_q  <= '0;
      off_q      <= '0;
    end else begin
      state_q <= state_d;
      rv_q    <= 1'b0;
      if (accept) begin
        x_q        <= pos[2*POS_BITS-1:POS_BITS];
        y_q        <= pos[POS_BITS-1:0];
        pad_q      <= {player_pos_right, player_pos_left, player_pos_down, player_pos_top};
        idx_q      <= '0;
        hit_acc_q  <= '0;
        miss_acc_q <= '0;
        off_acc_q  <= '0;
      end
      if (state_q == StScan) begin
        idx_q <= idx_q + 2'd1;
        if (hit_now) begin
          hit_acc_q[idx_q] <= 1'b1;
          // Offset belongs to the first (lowest-index) side that hits.
          if (hit_acc_q == '0) off_acc_q <= off_now;
        end
        if (miss_now) miss_acc_q[idx_q] <= 1'b1;
      end
      if (state_q == StDone) begin
        rv_q      <= 1'b1;
        hit_q     <= hit_acc_q;
        contact_q <= {|hit_acc_q[1:0], |hit_acc_q[3:2]};
        off_q     <= off_acc_q;
        miss_q    <= miss_acc_q;
      end
    end
  end

  assign busy         = (state_q != StIdle);
  assign result_valid = rv_q;
  assign hit_sides    = hit_q;
  assign contact      = contact_q;
  assign hit_offset   = off_q;
  assign miss_sides   = miss_q;

endmodule

// File: tb/tb_paddle_contact_scan.sv
// Bench for paddle_contact_scan: per-cycle comparison against a behavioural model, directed
// literal checks, and randomized traffic including overlapping requests and resets.
module tb_paddle_contact_scan;
  localparam int GW = 8;
  localparam int PL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pos_valid = 1'b0;
  logic [5:0] pos = '0;
  logic [3:0] pt = '0, pdn = '0, plf = '0, prt = '0;
  logic       busy, result_valid;
  logic [3:0] hit_sides, hit_offset, miss_sides;
  logic [1:0] contact;

  paddle_contact_scan dut (
    .clk              (clk),
    .rst              (rst),
    .pos_valid        (pos_valid),
    .pos              (pos),
    .player_pos_top   (pt),
    .player_pos_down  (pdn),
    .player_pos_left  (plf),
    .player_pos_right (prt),
    .busy             (busy),
    .result_valid     (result_valid),
    .hit_sides        (hit_sides),
    .contact          (contact),
    .hit_offset       (hit_offset),
    .miss_sides       (miss_sides)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0] hit;
    logic [1:0] con;
    logic [3:0] off;
    logic [3:0] miss;
  } res_t;

  function automatic res_t model(input int x, input int y, input int p0, input int p1,
                                 input int p2, input int p3);
    res_t r;
    int   pp[4];
    int   line_v, edge_v, c;
    bit   found;
    r = '0;
    found = 0;
    pp[0] = p0; pp[1] = p1; pp[2] = p2; pp[3] = p3;
    for (int s = 0; s < 4; s++) begin
      if (s < 2) begin
        c = x;
        line_v = (s == 0) ? 1 : GW - 2;
        edge_v = (s == 0) ? 0 : GW - 1;
        r.miss[s] = (y == edge_v);
        if (y == line_v && c >= pp[s] && c < pp[s] + PL) r.hit[s] = 1'b1;
      end else begin
        c = y;
        line_v = (s == 2) ? 1 : GW - 2;
        edge_v = (s == 2) ? 0 : GW - 1;
        r.miss[s] = (x == edge_v);
        if (x == line_v && c >= pp[s] && c < pp[s] + PL) r.hit[s] = 1'b1;
      end
      if (r.hit[s] && !found) begin
        r.off = 4'(c - pp[s]);
        found = 1;
      end
    end
`ifndef EDGE_MISS_EN
    r.miss = '0;
`endif
    r.con = {r.hit[0] | r.hit[1], r.hit[2] | r.hit[3]};
    return r;
  endfunction

  // Model: a request takes 5 more edges after acceptance, then the result appears.
  int   m_rem = 0;
  logic m_rv = 1'b0;
  res_t m_res = '0;
  res_t m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem <= 0;
      m_rv  <= 1'b0;
      m_res <= '0;
    end else begin
      m_rv <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_rv  <= 1'b1;
          m_res <= m_pend;
        end
      end else if (pos_valid) begin
        m_rem  <= 5;
        m_pend <= model(int'(pos[5:3]), int'(pos[2:0]), int'(pt), int'(pdn), int'(plf),
                        int'(prt));
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("result_valid", 32'(result_valid), 32'(m_rv));
    chk("hit_sides", 32'(hit_sides), 32'(m_res.hit));
    chk("contact", 32'(contact), 32'(m_res.con));
    chk("hit_offset", 32'(hit_offset), 32'(m_res.off));
    chk("miss_sides", 32'(miss_sides), 32'(m_res.miss));
  end

  task automatic drive(input int x, input int y, input int t, input int d, input int l,
                       input int r);
    pos = {x[2:0], y[2:0]};
    pt  = t[3:0];
    pdn = d[3:0];
    plf = l[3:0];
    prt = r[3:0];
  endtask

  // Issue one request and return at the negedge where result_valid is seen (or timeout).
  task automatic req(input int x, input int y, input int t, input int d, input int l,
                     input int r, output int lat);
    drive(x, y, t, d, l, r);
    pos_valid = 1'b1;
    @(negedge clk);
    pos_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic lit(input string tag, input logic [3:0] h, input logic [1:0] c,
                     input logic [3:0] o, input logic [3:0] m);
    chk({tag, "_hit"}, 32'(hit_sides), 32'(h));
    chk({tag, "_con"}, 32'(contact), 32'(c));
    chk({tag, "_off"}, 32'(hit_offset), 32'(o));
    chk({tag, "_miss"}, 32'(miss_sides), 32'(m));
  endtask

  function automatic int pick_coord();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      0: return 0;
      1, 2: return 1;
      3, 4: return GW - 2;
      5: return GW - 1;
      default: return int'($urandom_range(0, GW - 1));
    endcase
  endfunction

  initial begin
    int lat, n_rv;
    logic [3:0] seen_hit;
    logic [3:0] miss_exp;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    lit("rst", 4'b0000, 2'b00, 4'd0, 4'b0000);
    rst = 1'b0;
    @(negedge clk);

    req(1, 3, 0, 0, 3, 0, lat);
    chk("t2_latency", 32'(lat), 32'd6);
    lit("t2", 4'b0100, 2'b01, 4'd0, 4'b0000);
    @(negedge clk);

    req(1, 5, 0, 0, 3, 0, lat);
    lit("t3a", 4'b0000, 2'b00, 4'd0, 4'b0000);
    @(negedge clk);
    req(1, 5, 0, 0, 4, 0, lat);
    lit("t3b", 4'b0100, 2'b01, 4'd1, 4'b0000);
    @(negedge clk);

    req(1, 1, 1, 0, 0, 0, lat);
    lit("t4a", 4'b0101, 2'b11, 4'd0, 4'b0000);
    @(negedge clk);
    req(6, 6, 0, 5, 0, 6, lat);
    lit("t4b", 4'b1010, 2'b11, 4'd1, 4'b0000);
    @(negedge clk);

    // Re-pulses while busy must be ignored.
    drive(1, 3, 0, 0, 3, 0);
    pos_valid = 1'b1;
    n_rv = 0;
    seen_hit = 4'hf;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      pos_valid = (n == 2 || n == 4);
      if (n == 2) drive(1, 4, 0, 0, 0, 0);
      if (result_valid) begin
        n_rv++;
        seen_hit = hit_sides;
      end
    end
    pos_valid = 1'b0;
    chk("t5_pulses", 32'(n_rv), 32'd1);
    chk("t5_first_wins", 32'(seen_hit), 32'(4'b0100));

    // Reset in the middle of a scan aborts the request.
    req(1, 1, 1, 0, 0, 0, lat);
    @(negedge clk);
    drive(1, 3, 0, 0, 3, 0);
    pos_valid = 1'b1;
    @(negedge clk);
    pos_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_rv = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (result_valid) n_rv++;
    end
    chk("t5_abort_pulses", 32'(n_rv), 32'd0);
    lit("t5_abort", 4'b0000, 2'b00, 4'd0, 4'b0000);
    req(1, 3, 0, 0, 3, 0, lat);
    chk("t5_after_latency", 32'(lat), 32'd6);
    lit("t5_after", 4'b0100, 2'b01, 4'd0, 4'b0000);
    @(negedge clk);

`ifdef EDGE_MISS_EN
    miss_exp = 4'b0100;
`else
    miss_exp = 4'b0000;
`endif
    req(0, 4, 0, 0, 0, 0, lat);
    lit("t6", 4'b0000, 2'b00, 4'd0, miss_exp);
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      drive(pick_coord(), pick_coord(), int'($urandom_range(0, 9)),
            int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
            int'($urandom_range(0, 9)));
      if ($urandom_range(0, 15) == 0) pos[5:3] = 3'($urandom_range(0, 7));
      pos_valid = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    pos_valid = 1'b0;
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
